pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and next-PC controller for the single-cycle RISC-V core.
- Holds the architectural PC, which drives instruction memory and the PC+4 adder.
- Takes the adder's result back in and selects the next PC from: sequential, branch, jump, or trap vector.
- Adds boot sequencing, stall, halt/resume and misaligned-target trapping.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the PC this cycle (RUN state only).
- pc_plus4  input  32  sequential next PC from the PC+4 adder (pc + 4).
- branch_taken  input  1  conditional branch resolved taken.
- branch_target  input  32  branch destination.
- jump  input  1  JAL/JALR redirect.
- jump_target  input  32  jump destination.
- halt_req  input  1  request halt (debug/ebreak).
- resume  input  1  leave HALT.
- pc  output  32  current PC, to instruction memory and the PC+4 adder.
- fetch_valid  output  1  pc holds a valid fetch address this cycle.
- misalign_trap  output  1  one-cycle pulse, misaligned redirect taken.
- trap_epc  output  32  PC of the instruction that caused the last trap.
- halted  output  1  core halted.

Behaviour:
- States: BOOT, RUN, TRAP, HALT. Registered state.
- Reset (async, immediate, also mid-operation), then held while rst=1:
  - pc=RESET_VECTOR, state=BOOT.
  - fetch_valid=0, misalign_trap=0, trap_epc=0, halted=0.
- Outputs are Moore (decoded from state):
  - fetch_valid=1 only in RUN.
  - misalign_trap=1 only in TRAP.
  - halted=1 only in HALT.
- BOOT: pc holds; always goes to RUN next cycle. All inputs are ignored.
- RUN, priority highest first:
  1. halt_req=1: go to HALT; pc holds. Stall and redirects are ignored.
  2. stall=1: pc holds; stay in RUN. Redirects are dropped; upstream must hold them asserted.
  3. jump=1: candidate = jump_target. Jump wins over a simultaneous branch_taken.
  4. branch_taken=1: candidate = branch_target.
  5. Otherwise: candidate = pc_plus4. The alignment check is not applied to this candidate.
- Redirect candidate with target[1:0] != 2'b00:
  - pc <= TRAP_VECTOR, trap_epc <= current pc, go to TRAP.
- Aligned redirect or sequential candidate: pc <= candidate; stay in RUN.
- TRAP: exactly one cycle.
  - pc holds TRAP_VECTOR; fetch_valid=0.
  - Then go to RUN, which fetches TRAP_VECTOR.
  - stall, halt_req and redirects are ignored in this state.
- HALT: pc holds.
  - resume=1: go to RUN next cycle with pc unchanged.
  - halt_req is ignored while in HALT.
- Arithmetic:
  - The block contains no adder; pc_plus4 wraps naturally (32'hFFFF_FFFC -> 0). No overflow flag.
  - trap_epc changes only on trap entry and keeps its value otherwise.
- Timing: redirect latency is one cycle; pc shows the new target on the edge after the request.

Test Plan:
- Reset then release: pc=0 and fetch_valid=0 in BOOT. Next cycle RUN, fetch_valid=1. Following edges give pc 0, 4, 8 (pc_plus4 fed by the bench as pc+4).
- At pc=0x20, jump=1 with jump_target=0x80 and branch_taken=1 with branch_target=0x40 together -> pc=0x80 next cycle.
- At pc=0x30, stall=1 for 3 cycles with branch_taken=1 and target 0x100 -> pc stays 0x30 for all 3 cycles. Release stall with branch held -> pc=0x100.
- At pc=0x44, branch_taken=1 with target 0x52 ->
  - next cycle: pc=0x100, misalign_trap=1 for exactly one cycle, fetch_valid=0, trap_epc=0x44;
  - following cycle: RUN, then pc=0x104.
- At pc=0x60, halt_req=1 -> halted=1 and pc=0x60 for 5 cycles, with halt_req toggling during HALT having no effect. resume=1 -> RUN, then pc=0x64.
- Assert rst mid-run at pc=0x200, asynchronously between edges -> pc=0 and fetch_valid=0 immediately, without waiting for a clock edge.
- pc=0xFFFF_FFFC with pc_plus4=0 -> pc=0 next cycle with no trap.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and next-PC sequencing for the single-cycle core
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        misalign_trap,
  output logic [31:0] trap_epc,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state;
  logic        redirect;
  logic        misaligned;
  logic [31:0] candidate;

  // Jump outranks branch; the sequential candidate is never alignment-checked.
  always_comb begin
    redirect  = jump | branch_taken;
    candidate = pc_plus4;
    if (jump) begin
      candidate = jump_target;
    end else if (branch_taken) begin
      candidate = branch_target;
    end
    misaligned = redirect && (candidate[1:0] != 2'b00);
  end

  // Flag outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      trap_epc      <= 32'h0000_0000;
      fetch_valid   <= 1'b0;
      misalign_trap <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (!stall) begin
            if (misaligned) begin
              state         <= TRAP;
              pc            <= TRAP_VECTOR;
              trap_epc      <= pc;
              fetch_valid   <= 1'b0;
              misalign_trap <= 1'b1;
            end else begin
              pc <= candidate;
            end
          end
        end
        TRAP: begin
          state         <= RUN;
          fetch_valid   <= 1'b1;
          misalign_trap <= 1'b0;
        end
        HALT: begin
          if (resume) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: begin
          state         <= BOOT;
          pc            <= RESET_VECTOR;
          fetch_valid   <= 1'b0;
          misalign_trap <= 1'b0;
          halted        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl against a behavioural PC model
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] pc_plus4 = 32'd4;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        misalign_trap;
  logic [31:0] trap_epc;
  logic        halted;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt_req(halt_req),
    .resume(resume), .pc(pc), .fetch_valid(fetch_valid),
    .misalign_trap(misalign_trap), .trap_epc(trap_epc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        mt;
    logic [31:0] epc;
    logic        hl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0 boot, 1 running, 2 trapped, 3 halted.
  int          m_mode = 0;
  logic [31:0] m_pc   = RV;
  logic [31:0] m_epc  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_update();
    logic [31:0] tgt;
    exp_t e;
    if (rst) begin
      m_mode = 0; m_pc = RV; m_epc = 32'd0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (halt_req) m_mode = 3;
          else if (!stall) begin
            tgt = jump ? jump_target : (branch_taken ? branch_target : pc_plus4);
            if ((jump || branch_taken) && (tgt % 4 != 0)) begin
              m_epc = m_pc; m_pc = TV; m_mode = 2;
            end else m_pc = tgt;
          end
        end
        2: m_mode = 1;
        default: if (resume) m_mode = 1;
      endcase
    end
    e.pc = m_pc; e.fv = (m_mode == 1); e.mt = (m_mode == 2);
    e.epc = m_epc; e.hl = (m_mode == 3);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs at the falling edge, pc_plus4 tracks the model PC.
  task automatic cyc(input logic s, input logic br, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic h, input logic r);
    @(negedge clk);
    stall = s; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; halt_req = h; resume = r;
    pc_plus4 = m_pc + 32'd4;
    model_update();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare each registered result just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        check("misalign_trap", {31'd0, misalign_trap}, {31'd0, e.mt});
        check("trap_epc", trap_epc, e.epc);
        check("halted", {31'd0, halted}, {31'd0, e.hl});
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_update();
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_pc", pc, RV);
    check("boot_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    model_update();
    seq(3);

    // Jump beats a simultaneous branch.
    cyc(0, 0, 0, 1, 32'h20, 0, 0);
    cyc(0, 1, 32'h40, 1, 32'h80, 0, 0);

    // Stall drops a held branch until released.
    cyc(0, 0, 0, 1, 32'h30, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h100, 0, 0, 0, 0);
    cyc(0, 1, 32'h100, 0, 0, 0, 0);

    // Misaligned branch traps with epc of the branching PC.
    cyc(0, 0, 0, 1, 32'h44, 0, 0);
    cyc(0, 1, 32'h52, 0, 0, 0, 0);
    cyc(1, 1, 32'h8, 1, 32'h3, 1, 0);
    seq(2);

    // Halt, toggling halt_req while halted, then resume.
    cyc(0, 0, 0, 1, 32'h60, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, i % 2, 32'h10, 0, 0, i % 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    seq(1);

    // Sequential wrap at the top of the address space.
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    seq(2);

    // Asynchronous reset between edges.
    cyc(0, 0, 0, 1, 32'h200, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc, RV);
    check("async_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("async_rst_epc", trap_epc, 32'd0);
    model_update();
    @(negedge clk);
    rst = 1'b0;
    model_update();

    // Randomized traffic, occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom; jt = $urandom;
      if ($urandom_range(0, 2) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 2) != 0) jt[1:0] = 2'b00;
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      branch_target = bt;
      jump = ($urandom_range(0, 5) == 0);
      jump_target = jt;
      halt_req = ($urandom_range(0, 19) == 0);
      resume = ($urandom_range(0, 2) == 0);
      pc_plus4 = m_pc + 32'd4;
      model_update();
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
